// File: rtl/inv_cipher_iter.sv
// AES inverse cipher, iterative: one round per clock, on-chip key expansion one word per clock,
// with the expanded schedule cached for back-to-back blocks under the same key.
module inv_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [Nk*32-1:0] key,
  input  logic             key_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data
);

  localparam int NW = 4 * Nr + 4;
  localparam int IW = $clog2(NW);
  localparam int CW = $clog2(Nr + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEXP  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n sits at [127-8n]; row = n%4, column = n/4; row k rotates right by k
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t            state_r, state_s;
  logic [31:0]       w_r [NW];
  logic [IW-1:0]     kidx_r;
  logic [3:0]        kpos_r;
  logic [7:0]        rcon_r;
  logic [CW-1:0]     cnt_r;
  logic              cache_vld_r, in_ready_r, out_valid_r;
  logic [127:0]      out_data_r, st_r;
  logic [Nk*32-1:0]  cached_key_s;
  logic              hit_s;
  logic [31:0]       prev_s, temp_s, new_word_s;
  logic [127:0]      rk_s, iss_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Cache lookup, next schedule word and current round key
  always_comb begin
    cached_key_s = {(Nk*32){1'b0}};
    for (int k = 0; k < Nk; k++) begin
      cached_key_s[Nk*32-1-32*k -: 32] = w_r[k];
    end
    hit_s  = cache_vld_r && (key == cached_key_s) && !key_flush;
    prev_s = w_r[kidx_r - IW'(1)];
    if (kpos_r == 4'd0) begin
      temp_s = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon_r, 24'h000000};
    end else if ((Nk > 6) && (kpos_r == 4'd4)) begin
      temp_s = sub_word(prev_s);
    end else begin
      temp_s = prev_s;
    end
    new_word_s = w_r[kidx_r - IW'(Nk)] ^ temp_s;
    rk_s = 128'h0;
    for (int j = 0; j < 4; j++) begin
      rk_s[127-32*j -: 32] = w_r[IW'({cnt_r, 2'b00}) + IW'(j)];
    end
    iss_s = inv_sub_shift(st_r);
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = hit_s ? S_ROUND : S_KEXP;
        else          state_s = S_IDLE;
      end
      S_KEXP: begin
        if (kidx_r == IW'(NW - 1)) state_s = S_ROUND;
        else                       state_s = S_KEXP;
      end
      S_ROUND: begin
        if (cnt_r == {CW{1'b0}}) state_s = S_DONE;
        else                     state_s = S_ROUND;
      end
      S_DONE: begin
        if (out_ready) state_s = S_IDLE;
        else           state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Control registers, round datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 128'h0;
      cache_vld_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      kidx_r      <= {IW{1'b0}};
      kpos_r      <= 4'd0;
      rcon_r      <= 8'h01;
      st_r        <= 128'h0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            st_r   <= in_data;
            cnt_r  <= CW'(Nr);
            kidx_r <= IW'(Nk);
            kpos_r <= 4'd0;
            rcon_r <= 8'h01;
            if (!hit_s) cache_vld_r <= 1'b0;
          end else if (key_flush) begin
            cache_vld_r <= 1'b0;
          end
        end
        S_KEXP: begin
          kidx_r <= kidx_r + IW'(1);
          kpos_r <= (kpos_r == 4'(Nk - 1)) ? 4'd0 : kpos_r + 4'd1;
          if (kpos_r == 4'd0) rcon_r <= xtime(rcon_r);
          if (kidx_r == IW'(NW - 1)) cache_vld_r <= !key_flush;
          else if (key_flush)        cache_vld_r <= 1'b0;
        end
        S_ROUND: begin
          if (key_flush) cache_vld_r <= 1'b0;
          if (cnt_r == CW'(Nr)) begin
            st_r  <= st_r ^ rk_s;
            cnt_r <= cnt_r - CW'(1);
          end else if (cnt_r != {CW{1'b0}}) begin
            st_r  <= inv_mix(iss_s ^ rk_s);
            cnt_r <= cnt_r - CW'(1);
          end else begin
            out_data_r  <= iss_s ^ rk_s;
            out_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (key_flush) cache_vld_r <= 1'b0;
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Key schedule storage: the key itself on a miss, then one expanded word per cycle
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == S_IDLE) && in_valid && !hit_s) begin
      for (int k = 0; k < Nk; k++) begin
        w_r[k] <= key[Nk*32-1-32*k -: 32];
      end
    end else if (rst_n && (state_r == S_KEXP)) begin
      w_r[kidx_r] <= new_word_s;
    end
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench for inv_cipher_iter: FIPS-197 / SP800-38A vectors on AES-128/192/256 instances,
// latency, key-cache hit/miss, flush, backpressure and mid-transaction reset.
module tb_inv_cipher_iter;

  localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_B2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, key_flush, out_ready;
  logic [127:0] din;
  logic [255:0] key_bus;
  int           sel;
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];
  int           ncmp = 0;
  int           nfail = 0;

  always #5 clk = ~clk;

  inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 0)), .in_ready(ir[0]),
    .in_data(din), .key(key_bus[127:0]), .key_flush(key_flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));

  inv_cipher_iter #(.Nk(6), .Nr(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 1)), .in_ready(ir[1]),
    .in_data(din), .key(key_bus[191:0]), .key_flush(key_flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));

  inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2)), .in_ready(ir[2]),
    .in_data(din), .key(key_bus), .key_flush(key_flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block; returns at accept edge + 1
  task automatic start(input logic [255:0] k, input logic [127:0] ct, input logic fl);
    @(negedge clk);
    key_bus   = k;
    din       = ct;
    key_flush = fl;
    in_valid  = 1'b1;
    chk("in_ready_before_accept", {127'h0, ir[sel]}, 128'h1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    key_flush = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [255:0] k, input logic [127:0] ct,
                      input logic fl, input logic [127:0] exp_pt, input int exp_lat);
    int lat;
    start(k, ct, fl);
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, od[sel], exp_pt);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_out_valid_clear"}, {127'h0, ov[sel]}, 128'h0);
    chk({tag, "_in_ready_back"}, {127'h0, ir[sel]}, 128'h1);
  endtask

  task automatic abort_after(input string tag, input logic [255:0] k, input logic [127:0] ct, input int n);
    start(k, ct, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_in_ready"}, {127'h0, ir[sel]}, 128'h1);
    chk({tag, "_out_valid"}, {127'h0, ov[sel]}, 128'h0);
    chk({tag, "_out_data"}, od[sel], 128'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    key_flush = 1'b0;
    out_ready = 1'b1;
    din       = 128'h0;
    key_bus   = 256'h0;
    sel       = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", {127'h0, ir[i]}, 128'h1);
      chk("reset_out_valid", {127'h0, ov[i]}, 128'h0);
      chk("reset_out_data", od[i], 128'h0);
    end

    // AES-128 miss, then hit on the same key
    xfer("aes128_miss", {128'h0, K128A}, CT_A, 1'b0, PT0, 51);
    release_out("aes128_miss");
    xfer("aes128_hit", {128'h0, K128A}, CT_A, 1'b0, PT0, 11);
    release_out("aes128_hit");

    // Key change forces re-expansion, then a hit on the new key
    xfer("keyb_miss", {128'h0, K128B}, CT_B1, 1'b0, PT_B1, 51);
    release_out("keyb_miss");
    xfer("keyb_hit", {128'h0, K128B}, CT_B2, 1'b0, PT_B2, 11);
    release_out("keyb_hit");

    // AES-192 and AES-256
    sel = 1;
    xfer("aes192", {64'h0, K192}, CT192, 1'b0, PT0, 59);
    release_out("aes192");
    sel = 2;
    xfer("aes256", K256, CT256, 1'b0, PT0, 67);
    release_out("aes256");
    sel = 0;

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    xfer("bp", {128'h0, K128B}, CT_B1, 1'b0, PT_B1, 11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_data_stable", od[0], PT_B1);
      chk("bp_out_valid_held", {127'h0, ov[0]}, 128'h1);
      chk("bp_in_ready_low", {127'h0, ir[0]}, 128'h0);
    end
    release_out("bp");

    // Flush on the accept edge, then flush pulse while idle
    xfer("flush_accept", {128'h0, K128B}, CT_B1, 1'b1, PT_B1, 51);
    release_out("flush_accept");
    @(negedge clk);
    key_flush = 1'b1;
    @(posedge clk);
    #1;
    key_flush = 1'b0;
    chk("flush_idle_in_ready", {127'h0, ir[0]}, 128'h1);
    xfer("flush_idle", {128'h0, K128B}, CT_B2, 1'b0, PT_B2, 51);
    release_out("flush_idle");

    // Reset mid-ROUND (cached key) and mid-KEXP
    abort_after("rst_round", {128'h0, K128B}, CT_B1, 5);
    xfer("after_rst_round", {128'h0, K128B}, CT_B1, 1'b0, PT_B1, 51);
    release_out("after_rst_round");
    abort_after("rst_kexp", {128'h0, K128A}, CT_A, 10);
    xfer("after_rst_kexp", {128'h0, K128A}, CT_A, 1'b0, PT0, 51);
    release_out("after_rst_kexp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
